// File: rtl/uart_rx_port.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling FSM and a
// registered ready/valid output with frame-error and overrun pulses.
module uart_rx_port #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [IW-1:0]        idx, idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 rx_meta, rx_s;
    logic                 done, ferr;

    // Synchroniser flops reset to the idle-high line level.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            shift <= shift_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next = state;
        cnt_next   = cnt + 1'b1;
        idx_next   = idx;
        shift_next = shift;
        done       = 1'b0;
        ferr       = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (!rx_s) state_next = S_START;
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift[DATA_BITS-1:1]};
                    idx_next   = idx + 1'b1;
                    if (idx == IDX_LAST) state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        done       = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        ferr       = 1'b1;
                        state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line must return high before a new start is seen.
                cnt_next = '0;
                if (rx_s) state_next = S_IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= done && valid && !ready;
            if (done && (!valid || ready)) begin
                data_out <= shift;
                valid    <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port at 16 clocks per bit: idle, good frames,
// start glitch, framing error with break, overrun and mid-frame reset.
module tb_uart_rx_port;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data_out;
    logic       valid, frame_err, overrun, busy;

    int total = 0;
    int bad = 0;

    logic [7:0] got_q[$];
    int n_ferr = 0, n_ovr = 0, n_both = 0, n_noise = 0;
    bit watch_quiet = 1'b0;

    uart_rx_port #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk(clk),
        .reset(rst_n),
        .rx(rx),
        .data_out(data_out),
        .valid(valid),
        .ready(ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) got_q.push_back(data_out);
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (frame_err && overrun) n_both++;
            if (watch_quiet && (valid || busy || frame_err || overrun || data_out != 8'h00))
                n_noise++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            cycles(CPB);
        end
        rx = stop_bit;
        cycles(CPB);
    endtask

    int n0, f0, o0;

    initial begin
        // 1: reset and idle line
        cycles(3);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        watch_quiet = 1'b1;
        cycles(100);
        watch_quiet = 1'b0;
        check("idle_noise", n_noise, 0);
        check("idle_valid", valid, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_data", data_out, 8'h00);

        // 2: good frame 0xA5
        n0 = got_q.size(); f0 = n_ferr; o0 = n_ovr;
        send_frame(8'hA5, 1'b1);
        cycles(CPB);
        check("a5_count", got_q.size() - n0, 1);
        if (got_q.size() > n0) check("a5_data", got_q[n0], 8'hA5);
        check("a5_ferr", n_ferr - f0, 0);
        check("a5_ovr", n_ovr - o0, 0);
        check("a5_valid_after", valid, 1'b0);

        // 3: start glitch of 5 cycles
        n0 = got_q.size(); f0 = n_ferr;
        rx = 1'b0;
        cycles(5);
        check("glitch_busy", busy, 1'b1);
        rx = 1'b1;
        cycles(40);
        check("glitch_idle", busy, 1'b0);
        check("glitch_count", got_q.size() - n0, 0);
        check("glitch_ferr", n_ferr - f0, 0);

        // 4: bad stop bit followed by a held-low break
        n0 = got_q.size(); f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        cycles(3 * CPB);
        check("brk_ferr", n_ferr - f0, 1);
        check("brk_busy", busy, 1'b1);
        check("brk_count", got_q.size() - n0, 0);
        check("brk_valid", valid, 1'b0);
        rx = 1'b1;
        cycles(5);
        check("brk_release", busy, 1'b0);
        check("brk_ferr_once", n_ferr - f0, 1);

        // 5: overrun with consumer stalled
        cycles(CPB);
        n0 = got_q.size(); o0 = n_ovr; f0 = n_ferr;
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        cycles(CPB);
        check("ovr_first_valid", valid, 1'b1);
        check("ovr_first_data", data_out, 8'h11);
        send_frame(8'h22, 1'b1);
        cycles(CPB);
        check("ovr_pulse", n_ovr - o0, 1);
        check("ovr_hold_valid", valid, 1'b1);
        check("ovr_hold_data", data_out, 8'h11);
        check("ovr_no_ferr", n_ferr - f0, 0);
        ready = 1'b1;
        cycles(2);
        check("ovr_drain_valid", valid, 1'b0);
        check("ovr_drain_count", got_q.size() - n0, 1);
        if (got_q.size() > n0) check("ovr_drain_data", got_q[n0], 8'h11);

        // 6: reset in the middle of 0x5A, then 0xC3
        n0 = got_q.size(); f0 = n_ferr;
        rx = 1'b0;
        cycles(CPB);
        rx = 1'b0; cycles(CPB);
        rx = 1'b1; cycles(CPB);
        rx = 1'b0; cycles(CPB / 2);
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        cycles(3);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", valid, 1'b0);
        rx = 1'b1;
        cycles(1);
        rst_n = 1'b1;
        cycles(40);
        send_frame(8'hC3, 1'b1);
        cycles(CPB);
        check("c3_count", got_q.size() - n0, 1);
        if (got_q.size() > n0) check("c3_data", got_q[n0], 8'hC3);
        check("c3_ferr", n_ferr - f0, 0);

        check("never_both", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
